// File: rtl/bin2bcd_if.sv
// Start/done handshake bundle between the arithmetic result and the
// binary-to-BCD converter.
interface bin2bcd_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (output start, bin_in, input busy, done, bcd_out, overflow);
  modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per
// clock. Result is bin_in mod 10^DIGITS; overflow is the sticky OR of the
// bits shifted out of the top digit, i.e. set iff bin_in >= 10^DIGITS.
module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic      clk,
  input  logic      reset,
  bin2bcd_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                 state;
  logic [WIDTH-1:0]           bin_q;
  logic [DIGITS-1:0][3:0]     bcd_q;
  logic [DIGITS-1:0][3:0]     adj;
  logic [4*DIGITS:0]          cat;
  logic                       ovf_q;
  logic [CW-1:0]              cnt;
  logic                       done_q;
  logic                       ovf_out;
  logic [4*DIGITS-1:0]        bcd_out_q;

  // Add-3 correction on every digit that would reach >= 10 after doubling.
  genvar d;
  generate
    for (d = 0; d < DIGITS; d++) begin : g_dig
      assign adj[d] = (bcd_q[d] >= 4'd5) ? bcd_q[d] + 4'd3 : bcd_q[d];
    end
  endgenerate

  // Corrected digits with the next operand bit appended; the top bit is
  // what falls off the most significant digit on this shift.
  assign cat = {adj, bin_q[WIDTH-1]};

  // Control FSM and datapath. The result is registered on the final shift
  // so it is already valid in the single DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      cnt       <= '0;
      done_q    <= 1'b0;
      ovf_out   <= 1'b0;
      bcd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_q <= bus.bin_in;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt   <= CW'(WIDTH);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q <= bin_q << 1;
          bcd_q <= cat[4*DIGITS-1:0];
          ovf_q <= ovf_q | cat[4*DIGITS];
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bcd_out_q <= cat[4*DIGITS-1:0];
            ovf_out   <= ovf_q | cat[4*DIGITS];
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_out_q;
  assign bus.overflow = ovf_out;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: vector table, handshake corner sequences and
// random operands against an arithmetic (div/mod) reference model.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin2bcd_if #(.WIDTH(14), .DIGITS(4)) a();
  bin2bcd_if #(.WIDTH(8),  .DIGITS(3)) b();
  bin2bcd_if #(.WIDTH(8),  .DIGITS(2)) c();

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut_a (.clk(clk), .reset(reset), .bus(a));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut_b (.clk(clk), .reset(reset), .bus(b));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) dut_c (.clk(clk), .reset(reset), .bus(c));

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] prev_a = '0;

  typedef struct {
    int unsigned v;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] ref_bcd(input int unsigned v, input int dg);
    logic [15:0] r = '0;
    int unsigned x = v;
    for (int i = 0; i < dg; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v, input int dg);
    int unsigned p = 1;
    for (int i = 0; i < dg; i++) p = p * 10;
    return v >= p;
  endfunction

  // done must never be high on two consecutive cycles
  logic dprev = 1'b0;
  int   dbl   = 0;
  always @(negedge clk) begin
    if (a.done === 1'b1 && dprev) dbl <= dbl + 1;
    dprev <= (a.done === 1'b1);
  end

  // One conversion on the 14-bit/4-digit instance; cycle 1 is the cycle
  // right after the accepting edge.
  task automatic conv_a(input logic [13:0] v, output logic [15:0] bcd,
                        output logic ovf, output int lat, output int busy_n);
    @(negedge clk); a.start = 1'b1; a.bin_in = v;
    @(negedge clk); a.start = 1'b0; a.bin_in = 14'($urandom);
    check("a_hold", 32'(a.bcd_out), 32'(prev_a));
    lat = 1; busy_n = 0;
    while (a.done !== 1'b1 && lat < 64) begin
      if (a.busy === 1'b1) busy_n++;
      @(negedge clk); lat++;
    end
    if (a.busy === 1'b1) busy_n++;
    bcd = a.bcd_out; ovf = a.overflow;
    prev_a = bcd;
  endtask

  task automatic conv_b(input logic [7:0] v, output logic [11:0] bcd,
                        output logic ovf, output int lat);
    @(negedge clk); b.start = 1'b1; b.bin_in = v;
    @(negedge clk); b.start = 1'b0; b.bin_in = 8'($urandom);
    lat = 1;
    while (b.done !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
    bcd = b.bcd_out; ovf = b.overflow;
  endtask

  task automatic conv_c(input logic [7:0] v, output logic [7:0] bcd,
                        output logic ovf, output int lat);
    @(negedge clk); c.start = 1'b1; c.bin_in = v;
    @(negedge clk); c.start = 1'b0; c.bin_in = 8'($urandom);
    lat = 1;
    while (c.done !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
    bcd = c.bcd_out; ovf = c.overflow;
  endtask

  initial begin
    logic [15:0] r16, r1, r2;
    logic [11:0] r12;
    logic [7:0]  r8;
    logic        o, o1, o2;
    int          lat, bn, t1, t2, nd;
    logic [13:0] rv;

    vecs[0] = '{9325,  16'h9325, 1'b0};
    vecs[1] = '{0,     16'h0000, 1'b0};
    vecs[2] = '{9999,  16'h9999, 1'b0};
    vecs[3] = '{16383, 16'h6383, 1'b1};
    vecs[4] = '{10000, 16'h0000, 1'b1};
    vecs[5] = '{42,    16'h0042, 1'b0};
    vecs[6] = '{1,     16'h0001, 1'b0};
    vecs[7] = '{10,    16'h0010, 1'b0};

    reset = 1'b1;
    a.start = 1'b0; a.bin_in = '0;
    b.start = 1'b0; b.bin_in = '0;
    c.start = 1'b0; c.bin_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy",  32'(a.busy),     0);
    check("rst_done",  32'(a.done),     0);
    check("rst_bcd",   32'(a.bcd_out),  0);
    check("rst_ovf",   32'(a.overflow), 0);
    check("rst_b_bcd", 32'(b.bcd_out),  0);

    // table of directed vectors
    for (int i = 0; i < 8; i++) begin
      conv_a(14'(vecs[i].v), r16, o, lat, bn);
      check("tbl_bcd",  32'(r16), 32'(vecs[i].bcd));
      check("tbl_ovf",  32'(o),   32'(vecs[i].ovf));
      check("tbl_lat",  lat, 15);
      check("tbl_busy", bn,  15);
      @(negedge clk);
      check("tbl_busy_fall", 32'(a.busy), 0);
      check("tbl_done_fall", 32'(a.done), 0);
    end

    // back-to-back with start held high
    @(negedge clk); a.start = 1'b1; a.bin_in = 14'd0;
    @(negedge clk); a.bin_in = 14'd9999;
    t1 = 0; t2 = 0; r1 = '0; r2 = '0; o1 = 1'b1; o2 = 1'b1;
    for (int k = 1; k < 80 && t2 == 0; k++) begin
      if (a.done === 1'b1) begin
        if (t1 == 0) begin t1 = k; r1 = a.bcd_out; o1 = a.overflow; end
        else begin t2 = k; r2 = a.bcd_out; o2 = a.overflow; a.start = 1'b0; end
      end
      if (t2 == 0) @(negedge clk);
    end
    a.start = 1'b0;
    check("b2b_lat1", t1, 15);
    check("b2b_gap",  t2 - t1, 16);
    check("b2b_bcd1", 32'(r1), 32'h0000);
    check("b2b_bcd2", 32'(r2), 32'h9999);
    check("b2b_ovf",  32'({o1, o2}), 0);
    prev_a = 16'h9999;
    repeat (2) @(negedge clk);

    // start pulses and bin_in churn during SHIFT and DONE are ignored
    @(negedge clk); a.start = 1'b1; a.bin_in = 14'd4321;
    @(negedge clk);
    nd = 0; r16 = '0;
    for (int k = 1; k <= 20; k++) begin
      if (a.done === 1'b1) begin nd++; r16 = a.bcd_out; end
      a.start  = (k == 3 || k == 7 || k == 15);
      a.bin_in = 14'($urandom);
      @(negedge clk);
    end
    a.start = 1'b0;
    check("ign_ndone", nd, 1);
    check("ign_bcd",   32'(r16), 32'h4321);
    check("ign_idle",  32'(a.busy), 0);

    // reset five cycles into a conversion
    @(negedge clk); a.start = 1'b1; a.bin_in = 14'd1234;
    @(negedge clk); a.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("mid_rst_busy", 32'(a.busy),     0);
    check("mid_rst_done", 32'(a.done),     0);
    check("mid_rst_bcd",  32'(a.bcd_out),  0);
    check("mid_rst_ovf",  32'(a.overflow), 0);
    nd = 0;
    repeat (20) begin @(negedge clk); if (a.done === 1'b1) nd++; end
    check("mid_rst_nodone", nd, 0);
    // reset and start together: reset wins
    reset = 1'b1; a.start = 1'b1; a.bin_in = 14'd77;
    @(negedge clk); reset = 1'b0; a.start = 1'b0;
    check("rst_start_busy", 32'(a.busy), 0);
    @(negedge clk);
    check("rst_start_busy2", 32'(a.busy), 0);
    prev_a = '0;
    conv_a(14'd1234, r16, o, lat, bn);
    check("post_rst_bcd", 32'(r16), 32'h1234);
    check("post_rst_ovf", 32'(o), 0);

    // random operands against the model
    for (int i = 0; i < 30; i++) begin
      rv = 14'($urandom);
      conv_a(rv, r16, o, lat, bn);
      check("rnd_bcd", 32'(r16), 32'(ref_bcd(rv, 4)));
      check("rnd_ovf", 32'(o),   32'(ref_ovf(rv, 4)));
      check("rnd_lat", lat, 15);
    end

    // WIDTH=8, DIGITS=3 exhaustive
    for (int v = 0; v < 256; v++) begin
      conv_b(8'(v), r12, o, lat);
      check("b_bcd", 32'(r12), 32'(ref_bcd(v, 3) & 16'h0fff));
      check("b_ovf", 32'(o), 0);
      check("b_lat", lat, 9);
    end

    // WIDTH=8, DIGITS=2
    conv_c(8'd255, r8, o, lat);
    check("c_255_bcd", 32'(r8), 32'h55);
    check("c_255_ovf", 32'(o), 1);
    for (int i = 0; i < 20; i++) begin
      rv = 14'($urandom_range(0, 255));
      conv_c(rv[7:0], r8, o, lat);
      check("c_rnd_bcd", 32'(r8), 32'(ref_bcd(rv, 2) & 16'h00ff));
      check("c_rnd_ovf", 32'(o),  32'(ref_ovf(rv, 2)));
      check("c_rnd_lat", lat, 9);
    end

    @(negedge clk);
    check("done_consecutive", dbl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
